// File: rtl/cap_reg_bank_if.sv
// Bus bundle for cap_reg_bank: per-channel load/clear strobes in, captured words and status pulses out.
interface cap_reg_bank_if #(
  parameter int DW = 16,
  parameter int CH = 4
);
  logic [CH-1:0]    ld_en;
  logic [CH-1:0]    clr;
  logic [CH*DW-1:0] data_i;
  logic [CH*DW-1:0] data_o;
  logic [CH-1:0]    upd_o;
  logic [CH-1:0]    chg_o;
  logic [CH-1:0]    drop_o;
  logic [CH-1:0]    busy_o;

  modport master (
    output ld_en, clr, data_i,
    input  data_o, upd_o, chg_o, drop_o, busy_o
  );

  modport slave (
    input  ld_en, clr, data_i,
    output data_o, upd_o, chg_o, drop_o, busy_o
  );
endinterface

// File: rtl/cap_reg_bank.sv
// Multi-channel capture register bank with optional per-channel hold window.
// Each channel is an independent IDLE/HOLD machine keyed off its hold counter.
module cap_reg_bank #(
  parameter int            DW       = 16,
  parameter int            CH       = 4,
  parameter int            HOLD_CYC = 0,
  parameter logic [DW-1:0] RST_VAL  = '0,
  parameter string         REG_NAME = "cap_reg_bank"
) (
  input logic           clk,
  input logic           rst_n,
  cap_reg_bank_if.slave bus
);

  localparam int            CW      = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [DW-1:0] din;
    logic [DW-1:0] data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          upd_q, upd_d;
    logic          chg_q, chg_d;
    logic          drop_q, drop_d;
    logic          busy_q;
    state_e        state;

    assign din   = bus.data_i[c*DW +: DW];
    assign state = (cnt_q == '0) ? IDLE : HOLD;

    always_comb begin
      // NOTE: every signal gets a default before any branch, so no path can infer a latch.
      data_d = data_q;
      cnt_d  = (state == HOLD) ? cnt_q - 1'b1 : cnt_q;
      upd_d  = 1'b0;
      chg_d  = 1'b0;
      drop_d = 1'b0;
      if (bus.clr[c]) begin
        // Clear swallows a coincident load silently: no drop pulse.
        data_d = RST_VAL;
        cnt_d  = '0;
      end else if (bus.ld_en[c]) begin
        unique case (state)
          IDLE: begin
            data_d = din;
            upd_d  = 1'b1;
            chg_d  = (din != data_q);
            cnt_d  = HOLD_LD;
          end
          HOLD: drop_d = 1'b1;
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments; the captured word is reset too because RST_VAL is architecturally visible.
      if (!rst_n) begin
        data_q <= RST_VAL;
        cnt_q  <= '0;
        upd_q  <= 1'b0;
        chg_q  <= 1'b0;
        drop_q <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        data_q <= data_d;
        cnt_q  <= cnt_d;
        upd_q  <= upd_d;
        chg_q  <= chg_d;
        drop_q <= drop_d;
        busy_q <= (cnt_d != '0);
      end
    end

    assign bus.data_o[c*DW +: DW] = data_q;
    assign bus.upd_o[c]           = upd_q;
    assign bus.chg_o[c]           = chg_q;
    assign bus.drop_o[c]          = drop_q;
    assign bus.busy_o[c]          = busy_q;

`ifdef PLATFORM_SIM
    always @(posedge clk) begin
      assert (!$isunknown(bus.ld_en[c])) else $error("ld_en of %s: X on channel %0d", REG_NAME, c);
      assert (!$isunknown(bus.clr[c]))   else $error("clr of %s: X on channel %0d", REG_NAME, c);
    end
`endif
  end

endmodule

// File: tb/tb_cap_reg_bank.sv
// Scoreboard bench for cap_reg_bank: three instances with hold windows of 0, 3 and 2 cycles.
module tb_cap_reg_bank;

  localparam int            DW  = 16;
  localparam int            CH  = 4;
  localparam logic [DW-1:0] RST = 16'hA5A5;

  typedef struct {
    logic [CH*DW-1:0] data;
    logic [CH-1:0]    upd;
    logic [CH-1:0]    chg;
    logic [CH-1:0]    drop;
    logic [CH-1:0]    busy;
  } exp_t;

  logic clk;
  logic rst_n;

  cap_reg_bank_if #(.DW(DW), .CH(CH)) b0 ();
  cap_reg_bank_if #(.DW(DW), .CH(CH)) b3 ();
  cap_reg_bank_if #(.DW(DW), .CH(CH)) b2 ();

  cap_reg_bank #(.DW(DW), .CH(CH), .HOLD_CYC(0), .RST_VAL(RST), .REG_NAME("bank_h0"))
    u_h0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  cap_reg_bank #(.DW(DW), .CH(CH), .HOLD_CYC(3), .RST_VAL(RST), .REG_NAME("bank_h3"))
    u_h3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  cap_reg_bank #(.DW(DW), .CH(CH), .HOLD_CYC(2), .RST_VAL(RST), .REG_NAME("bank_h2"))
    u_h2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc1  = 0;
  int n_drop1 = 0;

  exp_t q0[$];
  exp_t q3[$];
  exp_t q2[$];
  exp_t mon_e;

  logic [DW-1:0] m_data [3][CH];
  int            m_cnt  [3][CH];
  int            hold_of [3] = '{0, 3, 2};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare(input string nm, input exp_t e, input logic [CH*DW-1:0] d,
                         input logic [CH-1:0] u, input logic [CH-1:0] ch,
                         input logic [CH-1:0] dr, input logic [CH-1:0] bz);
    check({nm, ".data"}, 64'(d),  64'(e.data));
    check({nm, ".upd"},  64'(u),  64'(e.upd));
    check({nm, ".chg"},  64'(ch), 64'(e.chg));
    check({nm, ".drop"}, 64'(dr), 64'(e.drop));
    check({nm, ".busy"}, 64'(bz), 64'(e.busy));
  endtask

  // Reference behaviour of one instance for the edge just taken.
  task automatic model(input int d, input logic rst, input logic [CH-1:0] ld,
                       input logic [CH-1:0] cl, input logic [CH*DW-1:0] din, output exp_t e);
    e.upd  = '0;
    e.chg  = '0;
    e.drop = '0;
    for (int c = 0; c < CH; c++) begin
      logic [DW-1:0] w;
      w = din[c*DW +: DW];
      if (!rst || cl[c]) begin
        m_data[d][c] = RST;
        m_cnt[d][c]  = 0;
      end else if (ld[c] && m_cnt[d][c] == 0) begin
        e.upd[c]     = 1'b1;
        e.chg[c]     = (w != m_data[d][c]);
        m_data[d][c] = w;
        m_cnt[d][c]  = hold_of[d];
      end else begin
        if (ld[c]) e.drop[c] = 1'b1;
        if (m_cnt[d][c] > 0) m_cnt[d][c]--;
      end
      e.data[c*DW +: DW] = m_data[d][c];
      e.busy[c]          = (m_cnt[d][c] != 0);
    end
  endtask

  // Inputs are driven at negedge; the model samples them at the posedge they are captured on.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    model(0, rst_n, b0.ld_en, b0.clr, b0.data_i, e); q0.push_back(e);
    model(1, rst_n, b3.ld_en, b3.clr, b3.data_i, e); q3.push_back(e);
    model(2, rst_n, b2.ld_en, b2.clr, b2.data_i, e); q2.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    b0.ld_en = '0; b0.clr = '0;
    b3.ld_en = '0; b3.clr = '0;
    b2.ld_en = '0; b2.clr = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) begin
      mon_e = q0.pop_front();
      compare("h0", mon_e, b0.data_o, b0.upd_o, b0.chg_o, b0.drop_o, b0.busy_o);
    end
    if (q3.size() > 0) begin
      mon_e = q3.pop_front();
      compare("h3", mon_e, b3.data_o, b3.upd_o, b3.chg_o, b3.drop_o, b3.busy_o);
    end
    if (q2.size() > 0) begin
      mon_e = q2.pop_front();
      compare("h2", mon_e, b2.data_o, b2.upd_o, b2.chg_o, b2.drop_o, b2.busy_o);
    end
    if (b3.upd_o[1] === 1'b1)  n_acc1++;
    if (b3.drop_o[1] === 1'b1) n_drop1++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    b0.ld_en = '0; b0.clr = '0; b0.data_i = '0;
    b3.ld_en = '0; b3.clr = '0; b3.data_i = '0;
    b2.ld_en = '0; b2.clr = '0; b2.data_i = '0;

    // Reset, then release with no loads: outputs stay at the reset value.
    tick(); tick();
    rst_n = 1'b1;
    idle(3);
    #1;
    check("rst.h0.data", 64'(b0.data_o), {4{RST}});
    check("rst.h3.busy", 64'(b3.busy_o), 64'(0));

    // Zero hold: repeated identical load updates without change; held strobe accepts every cycle.
    b0.ld_en[0] = 1'b1; b0.data_i[15:0] = 16'h1234; tick();
    b0.ld_en[0] = 1'b1; b0.data_i[15:0] = 16'h1234; tick();
    for (int i = 0; i < 3; i++) begin
      b0.data_i[15:0] = 16'h5A00 + 16'(i);
      tick();
    end
    idle(1);

    // Hold of 3 with the strobe held high on ch1: accepts at 0, 4, 8.
    for (int i = 0; i < 10; i++) begin
      b3.ld_en[1] = 1'b1;
      b3.data_i[31:16] = 16'(i);
      tick();
    end
    idle(4);
    #1;
    check("h3.ch1.accepts", 64'(n_acc1), 64'(3));
    check("h3.ch1.drops", 64'(n_drop1), 64'(7));
    check("h3.ch1.last", 64'(b3.data_o[31:16]), 64'h0008);

    // Clear with a coincident load mid-hold, then immediate re-accept on ch2.
    b3.ld_en[2] = 1'b1; b3.data_i[47:32] = 16'hBEEF; tick();
    b3.clr[2]   = 1'b1; b3.data_i[47:32] = 16'h1111; tick();
    b3.clr[2]   = 1'b0; b3.data_i[47:32] = 16'h2222; tick();
    idle(4);

    // Independence on the hold-2 bank: ch0 and ch3 loaded together, ch3 cleared mid-hold.
    b2.ld_en[0] = 1'b1; b2.ld_en[3] = 1'b1;
    b2.data_i[15:0] = 16'h0101; b2.data_i[63:48] = 16'h0303; tick();
    b2.ld_en[3] = 1'b0; b2.clr[3] = 1'b1; b2.data_i[15:0] = 16'h0202; tick();
    b2.clr[3] = 1'b0; b2.ld_en[3] = 1'b1; b2.data_i[63:48] = 16'h0404; tick();
    b2.ld_en[3] = 1'b0; b2.data_i[15:0] = 16'h0505; tick();
    idle(3);

    // Reset while ch0 of the hold-3 bank is mid-window, with a load pending.
    b3.ld_en[0] = 1'b1; b3.data_i[15:0] = 16'h7777; tick();
    idle(1);
    rst_n = 1'b0; b3.ld_en[0] = 1'b1; b3.data_i[15:0] = 16'h8888; tick();
    rst_n = 1'b1; b3.ld_en[0] = 1'b1; b3.data_i[15:0] = 16'h9999; tick();
    idle(3);
    #1;
    check("h3.ch0.after_rst", 64'(b3.data_o[15:0]), 64'h9999);
    check("queues.drained", 64'(q0.size() + q3.size() + q2.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
